// File: rtl/theremin_pkg.sv
// Shared types and 50 MHz timing constants for the theremin sensor path.
package theremin_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    GAP       = 3'd4
  } scan_state_t;

  localparam int unsigned TRIG_CYCLES_50M    = 500;
  localparam int unsigned TIMEOUT_CYCLES_50M = 1_500_000;
  localparam int unsigned GAP_CYCLES_50M     = 3_000_000;

  // Round-trip echo cycles per centimetre at 50 MHz (343 m/s, halved path).
  localparam int unsigned cycles_to_cm = 2915;

endpackage

// File: rtl/echo_sync.sv
// Parameterized-width 2-FF synchronizer with synchronous active-high reset.
module echo_sync #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/ultrasonic_scan_ctrl.sv
// Round-robin ultrasonic ping sequencer sharing one echo timer across sensors.
module ultrasonic_scan_ctrl
  import theremin_pkg::*;
#(
  parameter int NUM_SENSORS    = 2,
  parameter int TRIG_CYCLES    = TRIG_CYCLES_50M,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_50M,
  parameter int GAP_CYCLES     = GAP_CYCLES_50M,
  parameter int CNT_W          = 22,
  parameter int ID_W           = 1
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] echo_in,
  output logic [NUM_SENSORS-1:0] trig_out,
  output logic [CNT_W-1:0]       dist_cycles,
  output logic [ID_W-1:0]        dist_id,
  output logic                   dist_valid,
  output logic                   dist_timeout,
  output logic                   busy
);

  scan_state_t state_q, state_d;
  logic [CNT_W-1:0]       tmr_q, tmr_d;
  logic [ID_W-1:0]        cur_q, cur_d;
  logic [NUM_SENSORS-1:0] echo_s, echo_prev_q;
  logic [NUM_SENSORS-1:0] trig_q, trig_d;
  logic [CNT_W-1:0]       dist_q, dist_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic                   valid_q, valid_d, tmo_q, tmo_d;
  logic                   rise, fall;

  echo_sync #(.W(NUM_SENSORS)) u_sync (
    .clk_i (CLOCK_50),
    .rst_i (reset),
    .d_i   (echo_in),
    .q_o   (echo_s)
  );

  // Only the selected sensor's line is ever looked at.
  assign rise = echo_s[cur_q] & ~echo_prev_q[cur_q];
  assign fall = ~echo_s[cur_q] & echo_prev_q[cur_q];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      cur_q       <= '0;
      echo_prev_q <= '0;
      trig_q      <= '0;
      dist_q      <= '0;
      id_q        <= '0;
      valid_q     <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      cur_q       <= cur_d;
      echo_prev_q <= echo_s;
      trig_q      <= trig_d;
      dist_q      <= dist_d;
      id_q        <= id_d;
      valid_q     <= valid_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tmr_d   = tmr_q + CNT_W'(1);
    unique case (state_q)
      IDLE:      if (enable) state_d = TRIG;
      TRIG:      if (tmr_q == CNT_W'(TRIG_CYCLES - 1)) state_d = WAIT_RISE;
      WAIT_RISE: if (rise) state_d = MEASURE;
                 else if (tmr_q == CNT_W'(TIMEOUT_CYCLES)) state_d = GAP;
      MEASURE:   if (fall || tmr_q == CNT_W'(TIMEOUT_CYCLES)) state_d = GAP;
      GAP: begin
        if (tmr_q == CNT_W'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          cur_d   = (cur_q == ID_W'(NUM_SENSORS - 1)) ? '0 : cur_q + ID_W'(1);
        end
      end
      default:   state_d = IDLE;
    endcase
    if (state_d != state_q || state_q == IDLE) tmr_d = '0;
  end

  // MEASURE is entered one cycle after the synchronized rise, so the
  // high width is tmr + 1 when the fall is seen.
  always_comb begin
    trig_d  = '0;
    dist_d  = dist_q;
    id_d    = id_q;
    valid_d = 1'b0;
    tmo_d   = tmo_q;
    if (state_d == TRIG) trig_d[cur_d] = 1'b1;
    if (state_q == WAIT_RISE && !rise && tmr_q == CNT_W'(TIMEOUT_CYCLES)) begin
      valid_d = 1'b1;
      dist_d  = CNT_W'(TIMEOUT_CYCLES);
      tmo_d   = 1'b1;
      id_d    = cur_q;
    end else if (state_q == MEASURE && fall) begin
      valid_d = 1'b1;
      dist_d  = tmr_q + CNT_W'(1);
      tmo_d   = 1'b0;
      id_d    = cur_q;
    end else if (state_q == MEASURE && tmr_q == CNT_W'(TIMEOUT_CYCLES)) begin
      valid_d = 1'b1;
      dist_d  = CNT_W'(TIMEOUT_CYCLES);
      tmo_d   = 1'b1;
      id_d    = cur_q;
    end
  end

  assign trig_out     = trig_q;
  assign dist_cycles  = dist_q;
  assign dist_id      = id_q;
  assign dist_valid   = valid_q;
  assign dist_timeout = tmo_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ultrasonic_scan_ctrl.sv
// Directed bench for ultrasonic_scan_ctrl with shortened timing parameters.
module tb_ultrasonic_scan_ctrl;

  localparam int NS = 2;
  localparam int CW = 22;

  logic          clk = 1'b0;
  logic          reset, enable;
  logic [NS-1:0] echo_in;
  logic [NS-1:0] trig_out;
  logic [CW-1:0] dist_cycles;
  logic [0:0]    dist_id;
  logic          dist_valid, dist_timeout, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  int tf    = 0;

  ultrasonic_scan_ctrl #(
    .NUM_SENSORS(NS), .TRIG_CYCLES(4), .TIMEOUT_CYCLES(50), .GAP_CYCLES(10),
    .CNT_W(CW), .ID_W(1)
  ) dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .enable       (enable),
    .echo_in      (echo_in),
    .trig_out     (trig_out),
    .dist_cycles  (dist_cycles),
    .dist_id      (dist_id),
    .dist_valid   (dist_valid),
    .dist_timeout (dist_timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_trig(input string tag, input logic [NS-1:0] exp);
    int n = 0;
    while (trig_out == '0 && n < 300) begin tick(); n++; end
    t0 = cyc;
    chk(tag, {30'd0, trig_out}, {30'd0, exp});
  endtask

  task automatic wait_trig_low(input string tag);
    int n = 0;
    while (trig_out != '0 && n < 20) begin tick(); n++; end
    chk(tag, n, 4);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!dist_valid && n < 300) begin tick(); n++; end
    chk(tag, {31'd0, dist_valid}, 1);
  endtask

  task automatic chk_result(input string tag, input int d, input int id, input int tmo);
    chk({tag, "_dist"}, dist_cycles, d);
    chk({tag, "_id"}, {31'd0, dist_id}, id);
    chk({tag, "_tmo"}, {31'd0, dist_timeout}, tmo);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_trig"}, {30'd0, trig_out}, 0);
    chk({tag, "_dist"}, dist_cycles, 0);
    chk({tag, "_id"}, {31'd0, dist_id}, 0);
    chk({tag, "_valid"}, {31'd0, dist_valid}, 0);
    chk({tag, "_tmo"}, {31'd0, dist_timeout}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  initial begin
    int n;
    reset   = 1'b1;
    enable  = 1'b0;
    echo_in = '0;
    repeat (3) tick();
    chk_idle_outputs("rst");

    // Basic ping on sensor 0: 20-cycle echo starting 5 cycles after trig falls.
    enable = 1'b1;
    reset  = 1'b0;
    wait_trig("p1_trig", 2'b01);
    chk("p1_busy", {31'd0, busy}, 1);
    wait_trig_low("p1_trig_w");
    repeat (5) tick();
    echo_in[0] = 1'b1;
    repeat (20) tick();
    echo_in[0] = 1'b0;
    tf = cyc;
    wait_valid("p1_valid");
    chk("p1_lat", cyc - tf, 3);
    chk_result("p1", 20, 0, 0);
    tick();
    chk("p1_strobe", {31'd0, dist_valid}, 0);
    chk("p1_hold", dist_cycles, 20);

    // Round-robin to sensor 1; a pulse on sensor 0 must be ignored.
    wait_trig("p2_trig", 2'b10);
    wait_trig_low("p2_trig_w");
    echo_in[0] = 1'b1;
    repeat (3) tick();
    echo_in[0] = 1'b0;
    repeat (2) tick();
    echo_in[1] = 1'b1;
    repeat (7) tick();
    echo_in[1] = 1'b0;
    wait_valid("p2_valid");
    chk_result("p2", 7, 1, 0);

    // No echo on sensor 0.
    wait_trig("p3_trig", 2'b01);
    wait_valid("p3_valid");
    chk("p3_lat", cyc - t0, 55);
    chk_result("p3", 50, 0, 1);

    // 60-cycle echo on sensor 1 saturates; sensor 0 goes stuck high meanwhile.
    wait_trig("p4_trig", 2'b10);
    wait_trig_low("p4_trig_w");
    repeat (2) tick();
    echo_in = 2'b11;
    repeat (60) tick();
    echo_in[1] = 1'b0;
    chk("p4_valid_seen", {31'd0, dist_valid}, 0);
    chk_result("p4", 50, 1, 1);

    // Stuck-high sensor 0 times out in WAIT_RISE.
    wait_trig("p5_trig", 2'b01);
    wait_valid("p5_valid");
    chk("p5_lat", cyc - t0, 55);
    chk_result("p5", 50, 0, 1);
    echo_in[0] = 1'b0;

    // enable drops mid-MEASURE: result still arrives, then scanning stops.
    wait_trig("p6_trig", 2'b10);
    wait_trig_low("p6_trig_w");
    repeat (2) tick();
    echo_in[1] = 1'b1;
    repeat (3) tick();
    enable = 1'b0;
    repeat (5) tick();
    echo_in[1] = 1'b0;
    wait_valid("p6_valid");
    chk_result("p6", 8, 1, 0);
    chk("p6_busy_gap", {31'd0, busy}, 1);
    n = 0;
    while (busy && n < 30) begin tick(); n++; end
    chk("p6_busy_end", {31'd0, busy}, 0);
    n = 0;
    repeat (20) begin
      tick();
      if (trig_out != '0 || busy) n++;
    end
    chk("p6_no_trig", n, 0);

    // Reset during a sensor-1 trigger clears everything and cur.
    enable = 1'b1;
    wait_trig("p7_trig", 2'b01);
    wait_valid("p7_valid");
    chk_result("p7", 50, 0, 1);
    wait_trig("p8_trig", 2'b10);
    tick();
    reset = 1'b1;
    tick();
    chk_idle_outputs("mid_rst");
    reset = 1'b0;
    wait_trig("p9_trig", 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
